// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - RV32I instruction fetch: byte-serial fetch over a shared port, presents {pc, inst} to IF/ID
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    typedef enum logic {
        S_FETCH,
        S_OUT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [2:0]  issue_cnt_q;
    logic [2:0]  recv_cnt_q;
    logic        pend_q;
    logic [31:0] inst_buf_q;
    logic [31:0] pc_o_q;
    logic [31:0] inst_o_q;

    logic        accept_d;
    logic [31:0] inst_done_d;

    assign mem_req_o  = (state_q == S_FETCH) && !issue_cnt_q[2];
    assign mem_addr_o = pc_q + {29'd0, issue_cnt_q};
    assign accept_d   = mem_req_o && mem_grant_i;
    // Last byte merged straight into the presented word so OUT sees it on entry.
    assign inst_done_d = {mem_rdata_i, inst_buf_q[23:0]};

    assign pc_o    = pc_o_q;
    assign inst_o  = inst_o_q;
    assign valid_o = (state_q == S_OUT) && !jump_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            pend_q      <= 1'b0;
            inst_buf_q  <= 32'd0;
            pc_o_q      <= 32'd0;
            inst_o_q    <= 32'd0;
        end else if (jump_i) begin
            // Clearing pend discards the byte answering this cycle's request.
            state_q     <= S_FETCH;
            pc_q        <= jump_addr_i;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            pend_q      <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    pend_q <= accept_d;
                    if (accept_d) begin
                        issue_cnt_q <= issue_cnt_q + 3'd1;
                    end
                    if (pend_q) begin
                        inst_buf_q[{recv_cnt_q[1:0], 3'b000} +: 8] <= mem_rdata_i;
                        recv_cnt_q <= recv_cnt_q + 3'd1;
                        if (recv_cnt_q == 3'd3) begin
                            state_q  <= S_OUT;
                            pc_o_q   <= pc_q;
                            inst_o_q <= inst_done_d;
                        end
                    end
                end
                S_OUT: begin
                    if (!stall_i) begin
                        state_q     <= S_FETCH;
                        pc_q        <= pc_q + 32'd4;
                        issue_cnt_q <= 3'd0;
                        recv_cnt_q  <= 3'd0;
                        pend_q      <= 1'b0;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed and randomized checks of if_fetch against a fetch-sequence reference model
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = 32'd0;
    logic        mem_grant_i = 1'b1;
    logic [7:0]  mem_rdata_i = 8'd0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;

    logic [7:0]  w_rdata = 8'd0;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic        w_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic        o_req, o_valid, ow_valid;
    logic [31:0] o_addr, o_pc, o_inst, ow_addr, ow_pc, ow_inst;

    logic        model_en = 1'b0;
    logic [31:0] exp_pc;
    int          exp_k;
    int          n_handoff;

    always #5 clk = ~clk;

    if_fetch u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_grant_i(mem_grant_i),
        .mem_rdata_i(mem_rdata_i), .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst), .stall_i(stall_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .mem_req_o(w_req), .mem_addr_o(w_addr), .mem_grant_i(mem_grant_i),
        .mem_rdata_i(w_rdata), .pc_o(w_pc), .inst_o(w_inst), .valid_o(w_valid)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] boot;
        boot = 32'h0010_0513;
        if (a < 32'd4) return boot[8*a[1:0] +: 8];
        return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: each presented word is the next sequential (or redirected) pc, fetched as pc..pc+3.
    task automatic model_step();
        if (mem_req_o && mem_grant_i) begin
            check("rnd_addr", mem_addr_o, exp_pc + exp_k);
            exp_k++;
        end
        if (valid_o) begin
            check("rnd_pc", pc_o, exp_pc);
            check("rnd_inst", inst_o, mem_word(exp_pc));
            check("rnd_issued", exp_k, 4);
        end
        if (jump_i) begin
            exp_pc = jump_addr_i;
            exp_k  = 0;
        end else if (valid_o && !stall_i) begin
            exp_pc = exp_pc + 32'd4;
            exp_k  = 0;
            n_handoff++;
        end
    endtask

    task automatic tick(input logic st, input logic jp, input logic [31:0] ja, input logic gr);
        logic acc, wacc;
        logic [31:0] acc_a, wacc_a;
        stall_i = st; jump_i = jp; jump_addr_i = ja; mem_grant_i = gr;
        @(negedge clk);
        o_req = mem_req_o; o_addr = mem_addr_o; o_valid = valid_o; o_pc = pc_o; o_inst = inst_o;
        ow_addr = w_addr; ow_valid = w_valid; ow_pc = w_pc; ow_inst = w_inst;
        if (model_en) model_step();
        acc = mem_req_o && mem_grant_i; acc_a = mem_addr_o;
        wacc = w_req && mem_grant_i; wacc_a = w_addr;
        @(posedge clk);
        #1;
        mem_rdata_i = acc ? mem_byte(acc_a) : 8'($urandom);
        w_rdata     = wacc ? mem_byte(wacc_a) : 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        rst = 1'b1;
    endtask

    initial begin
        int first;

        // Reset values and nominal timing.
        do_reset();
        check("rst_pc", o_pc, 0);
        check("rst_inst", o_inst, 0);
        check("rst_valid", o_valid, 0);
        check("rst_addr", o_addr, 0);
        for (int c = 0; c <= 15; c++) begin
            tick((c >= 11 && c <= 13), 0, 0, 1);
            if (c < 4) begin
                check("nom_addr", o_addr, c);
                check("nom_req", o_req, 1);
            end
            if (c == 4) check("nom_req_done", o_req, 0);
            if (c <= 4 || (c >= 6 && c <= 10)) check("nom_valid_lo", o_valid, 0);
            if (c == 5) begin
                check("nom_valid", o_valid, 1);
                check("nom_inst", o_inst, 32'h0010_0513);
                check("nom_pc", o_pc, 0);
            end
            if (c == 6) check("nom_next_addr", o_addr, 4);
            if (c >= 11 && c <= 14) begin
                check("stall_valid", o_valid, 1);
                check("stall_pc", o_pc, 4);
                check("stall_inst", o_inst, mem_word(4));
                check("stall_req", o_req, 0);
            end
            if (c == 15) check("stall_next_addr", o_addr, 8);
        end

        // Grant denied in cycles 1-2.
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            tick(0, 0, 0, !(c == 1 || c == 2));
            if (c >= 1 && c <= 3) check("deny_addr_hold", o_addr, 1);
            if (c == 6) check("deny_valid_lo", o_valid, 0);
            if (c == 7) begin
                check("deny_valid", o_valid, 1);
                check("deny_inst", o_inst, 32'h0010_0513);
            end
        end

        // Redirect mid-fetch, then redirect during a stalled OUT.
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            if (c == 14) tick(1, 1, 32'h200, 1);
            else tick(0, (c == 2), 32'h100, 1);
            if (c >= 3 && c <= 6) check("jmp_addr", o_addr, 32'h100 + c - 3);
            if (c == 7 || c == 13) check("jmp_valid_lo", o_valid, 0);
            if (c == 8) begin
                check("jmp_valid", o_valid, 1);
                check("jmp_pc", o_pc, 32'h100);
                check("jmp_inst", o_inst, mem_word(32'h100));
            end
            if (c == 14) check("out_jmp_valid", o_valid, 0);
        end
        first = -1;
        for (int c = 15; c <= 30; c++) begin
            tick(0, 0, 0, 1);
            if (o_valid) begin
                first = c;
                break;
            end
        end
        check("out_jmp_latency", first, 20);
        check("out_jmp_pc", o_pc, 32'h200);
        check("out_jmp_inst", o_inst, mem_word(32'h200));

        // Reset asserted in the third cycle of a fetch.
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        rst = 1'b0;
        tick(0, 0, 0, 1);
        rst = 1'b1;
        tick(0, 0, 0, 1);
        check("mid_rst_pc", o_pc, 0);
        check("mid_rst_inst", o_inst, 0);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_addr", o_addr, 0);
        for (int c = 1; c <= 5; c++) tick(0, 0, 0, 1);
        check("mid_rst_refetch", o_valid, 1);
        check("mid_rst_refetch_inst", o_inst, 32'h0010_0513);

        // Address wrap with RESET_PC at the top of memory.
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            tick(0, 0, 0, 1);
            if (c < 4) check("wrap_addr", ow_addr, 32'hFFFF_FFFC + c);
            if (c == 5) begin
                check("wrap_valid", ow_valid, 1);
                check("wrap_pc", ow_pc, 32'hFFFF_FFFC);
                check("wrap_inst", ow_inst, mem_word(32'hFFFF_FFFC));
            end
            if (c == 6) check("wrap_next_addr", ow_addr, 0);
        end

        // Randomized grant/stall/redirect against the reference model.
        do_reset();
        exp_pc = 32'd0;
        exp_k = 0;
        n_handoff = 0;
        model_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom % 10) < 3, ($urandom % 40) == 0, $urandom, ($urandom % 4) != 0);
        end
        model_en = 1'b0;
        check("rnd_progress", (n_handoff > 50), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
